// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Multiplexes a NUM_DIG-digit common-anode seven-segment display fed by the
// BCD calculate stage. Each digit owns one slot of DIV = CLK_FREQ/SCAN_HZ
// clock cycles. The first BLANK_CYC cycles of every slot are dark so the
// previous digit's segments never ghost onto the next digit. Inputs are
// snapshotted once per frame, at the start of digit 0's slot, so a frame that
// is being displayed never mixes old and new data.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   data_in      4*NUM_DIG bits, nibble i is digit i (digit 0 is rightmost)
//   dat_en       NUM_DIG bits, 1 = digit i is lit during its slot
//   dot_en       NUM_DIG bits, 1 = decimal point lit on digit i (when lit)
//   seg_sel      NUM_DIG bits, active-low digit select, bit i drives digit i
//   seg_data     8 bits, active-low segments {dp,g,f,e,d,c,b,a}
//   frame_start  one-cycle pulse, the cycle after each input snapshot
//
// All outputs are registered and reflect the slot position of the previous
// cycle.
// ---------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int NUM_DIG   = 8,
    parameter int CLK_FREQ  = 12000000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*NUM_DIG-1:0] data_in,
    input  logic [NUM_DIG-1:0]   dat_en,
    input  logic [NUM_DIG-1:0]   dot_en,
    output logic [NUM_DIG-1:0]   seg_sel,
    output logic [7:0]           seg_data,
    output logic                 frame_start
);

    localparam int DIV   = CLK_FREQ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIG - 1);

    // Each slot is split into a dark lead-in and a lit remainder.
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [4*NUM_DIG-1:0] snap_data;
    logic [NUM_DIG-1:0]   snap_dat;
    logic [NUM_DIG-1:0]   snap_dot;

    logic                 frame_edge;
    phase_t               phase;
    logic [3:0]           cur_nib;
    logic [NUM_DIG-1:0]   sel_next;
    logic [7:0]           data_next;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}. Codes A..F are not hex
    // letters: A is a minus sign, B/D render as lower-case b/d, F is blank.
    function automatic logic [7:0] decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0:    pat = 8'hC0;
            4'h1:    pat = 8'hF9;
            4'h2:    pat = 8'hA4;
            4'h3:    pat = 8'hB0;
            4'h4:    pat = 8'h99;
            4'h5:    pat = 8'h92;
            4'h6:    pat = 8'h82;
            4'h7:    pat = 8'hF8;
            4'h8:    pat = 8'h80;
            4'h9:    pat = 8'h90;
            4'hA:    pat = 8'hBF;
            4'hB:    pat = 8'h83;
            4'hC:    pat = 8'hC6;
            4'hD:    pat = 8'hA1;
            4'hE:    pat = 8'h86;
            default: pat = 8'hFF;
        endcase
        return pat;
    endfunction

    // The first cycle of digit 0's slot marks the frame boundary.
    always_comb begin
        frame_edge = (cnt == '0) && (idx == '0);
    end

    // Slot counter and digit index. idx advances on the last cycle of a slot
    // and wraps after the leftmost digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame snapshot. Captured while the display is blanked at the start of
    // slot 0, so the new snapshot is in place before any digit is lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_data   <= '0;
            snap_dat    <= '0;
            snap_dot    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_edge;
            if (frame_edge) begin
                snap_data <= data_in;
                snap_dat  <= dat_en;
                snap_dot  <= dot_en;
            end
        end
    end

    // Phase is a pure decode of the slot counter; no separate state register
    // is needed because the counter already encodes where we are in the slot.
    always_comb begin
        phase = PH_SHOW;
        if (cnt < BLANK_END) begin
            phase = PH_BLANK;
        end
    end

    // Next output values. Everything defaults to dark; only a SHOW cycle of
    // an enabled digit drives exactly one select low.
    always_comb begin
        sel_next  = '1;
        data_next = 8'hFF;
        cur_nib   = snap_data[{idx, 2'b00} +: 4];
        if (phase == PH_SHOW && snap_dat[idx]) begin
            sel_next  = ~(NUM_DIG'(1) << idx);
            data_next = decode(cur_nib);
            if (snap_dot[idx]) begin
                data_next[7] = 1'b0;
            end
        end
    end

    // Registered outputs keep the pins glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_sel  <= '1;
            seg_data <= 8'hFF;
        end else begin
            seg_sel  <= sel_next;
            seg_data <= data_next;
        end
    end

endmodule
